parity_bist_ctrl: RTL and testbench

PARITY_BIST_CTRL -- requirements
Module: parity_bist_ctrl

---
 rtl/parity_bist_ctrl.sv | 137 +++++++++++++
 tb/tb_parity_bist_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_bist_ctrl.sv
// Built-in self test sequencer for a 3-input parity cell: walks all eight input
// vectors, compares the returned parity and reports error count and first failure.
module parity_bist_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       parity_sel,
    input  logic [3:0] settle,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    input  logic       dut_p,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail,
    output logic       fail_valid
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    state_t     state, state_n;
    logic [2:0] vec, vec_n;
    logic [3:0] cnt, cnt_n;
    logic       psel_l, psel_l_n;
    logic [3:0] settle_l, settle_l_n;
    logic [3:0] err_cnt_n;
    logic [2:0] first_fail_n;
    logic       fail_valid_n;
    logic       pass_n;
    logic       mismatch;

    // Parity the unit under test should return for vector v; sel selects odd parity.
    function automatic logic expected_parity(input logic [2:0] v, input logic sel);
        return (v[2] ^ v[1] ^ v[0]) ^ sel;
    endfunction

    assign mismatch = (dut_p != expected_parity(vec, psel_l));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 3'd0;
            cnt        <= 4'd0;
            psel_l     <= 1'b0;
            settle_l   <= 4'd0;
            err_cnt    <= 4'd0;
            first_fail <= 3'd0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state      <= state_n;
            vec        <= vec_n;
            cnt        <= cnt_n;
            psel_l     <= psel_l_n;
            settle_l   <= settle_l_n;
            err_cnt    <= err_cnt_n;
            first_fail <= first_fail_n;
            fail_valid <= fail_valid_n;
            pass       <= pass_n;
        end
    end

    always_comb begin
        state_n      = state;
        vec_n        = vec;
        cnt_n        = cnt;
        psel_l_n     = psel_l;
        settle_l_n   = settle_l;
        err_cnt_n    = err_cnt;
        first_fail_n = first_fail;
        fail_valid_n = fail_valid;
        pass_n       = pass;

        case (state)
            IDLE: begin
                // Results of the previous run stay visible until a new run is accepted.
                if (start) begin
                    psel_l_n     = parity_sel;
                    settle_l_n   = settle;
                    vec_n        = 3'd0;
                    err_cnt_n    = 4'd0;
                    first_fail_n = 3'd0;
                    fail_valid_n = 1'b0;
                    pass_n       = 1'b0;
                    state_n      = DRIVE;
                end
            end
            DRIVE: begin
                cnt_n   = settle_l;
                state_n = (settle_l != 4'd0) ? WAIT : SAMPLE;
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_cnt_n = err_cnt + 4'd1;
                    if (!fail_valid) begin
                        first_fail_n = vec;
                        fail_valid_n = 1'b1;
                    end
                end
                if (vec == 3'd7) begin
                    state_n = DONE;
                end else begin
                    vec_n   = vec + 3'd1;
                    state_n = DRIVE;
                end
            end
            DONE: begin
                // err_cnt already includes the final sample here.
                pass_n  = (err_cnt == 4'd0);
                vec_n   = 3'd0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign {dut_a, dut_b, dut_c} = vec;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_parity_bist_ctrl.sv
// Directed bench for parity_bist_ctrl with a behavioural parity cell whose
// output can be inverted per vector through fault_mask.
module tb_parity_bist_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       parity_sel;
    logic [3:0] settle;
    logic       dut_a, dut_b, dut_c;
    logic       dut_p;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [2:0] first_fail;
    logic       fail_valid;

    logic [7:0] fault_mask;
    logic [2:0] dvec;

    int n_cmp;
    int n_bad;

    // Observations collected by run()
    logic [2:0] first_vec;
    logic       order_ok;
    int         n_changes;
    logic       pass_seen;
    logic       post_pass, post_done, post_busy;
    logic [2:0] post_vec;

    parity_bist_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .parity_sel (parity_sel),
        .settle     (settle),
        .dut_a      (dut_a),
        .dut_b      (dut_b),
        .dut_c      (dut_c),
        .dut_p      (dut_p),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .first_fail (first_fail),
        .fail_valid (fail_valid)
    );

    assign dvec  = {dut_a, dut_b, dut_c};
    assign dut_p = (dut_a ^ dut_b ^ dut_c) ^ fault_mask[dvec];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse start, then change the run-time inputs; edges = cycles to done, -1 on timeout.
    task automatic run(input logic psel, input logic [3:0] s, input logic [3:0] s_after,
                       output int edges);
        logic [2:0] prev;
        @(negedge clk);
        parity_sel = psel;
        settle     = s;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        parity_sel = ~psel;
        settle     = s_after;
        first_vec  = dvec;
        prev       = dvec;
        order_ok   = 1'b1;
        n_changes  = 0;
        pass_seen  = pass;
        edges      = -1;
        post_pass  = 1'bx;
        post_done  = 1'bx;
        post_busy  = 1'bx;
        post_vec   = 3'bxxx;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (dvec != prev) begin
                if (dvec != prev + 3'd1) order_ok = 1'b0;
                n_changes++;
                prev = dvec;
            end
            if (pass) pass_seen = 1'b1;
            if (done) begin
                edges = n;
                break;
            end
        end
        if (edges > 0) begin
            @(posedge clk);
            #1;
            post_pass = pass;
            post_done = done;
            post_busy = busy;
            post_vec  = dvec;
            if (pass) pass_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %b expected 0", pass); end
        n_cmp++; if (err_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        n_cmp++; if (first_fail !== 3'd0) begin n_bad++; $display("FAIL reset_first_fail: got %0d expected 0", first_fail); end
        n_cmp++; if (fail_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fail_valid: got %b expected 0", fail_valid); end
        n_cmp++; if (dvec !== 3'd0) begin n_bad++; $display("FAIL reset_vec: got %0d expected 0", dvec); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_start: busy got %b expected 0", busy); end
    endtask

    task automatic test_good_run();
        int e;
        fault_mask = 8'h00;
        run(1'b0, 4'd0, 4'd5, e);
        n_cmp++; if (e !== 16) begin n_bad++; $display("FAIL good_latency: got %0d expected 16", e); end
        n_cmp++; if (first_vec !== 3'd0) begin n_bad++; $display("FAIL good_first_vec: got %0d expected 0", first_vec); end
        n_cmp++; if (order_ok !== 1'b1) begin n_bad++; $display("FAIL good_vec_order: got %b expected 1", order_ok); end
        n_cmp++; if (n_changes !== 7) begin n_bad++; $display("FAIL good_vec_steps: got %0d expected 7", n_changes); end
        n_cmp++; if (err_cnt !== 4'd0) begin n_bad++; $display("FAIL good_err_cnt: got %0d expected 0", err_cnt); end
        n_cmp++; if (fail_valid !== 1'b0) begin n_bad++; $display("FAIL good_fail_valid: got %b expected 0", fail_valid); end
        n_cmp++; if (post_pass !== 1'b1) begin n_bad++; $display("FAIL good_pass: got %b expected 1", post_pass); end
        n_cmp++; if (post_done !== 1'b0) begin n_bad++; $display("FAIL good_done_width: got %b expected 0", post_done); end
        n_cmp++; if (post_busy !== 1'b0) begin n_bad++; $display("FAIL good_busy_after: got %b expected 0", post_busy); end
        n_cmp++; if (post_vec !== 3'd0) begin n_bad++; $display("FAIL good_vec_after: got %0d expected 0", post_vec); end
    endtask

    task automatic test_inverted_sel();
        int e;
        fault_mask = 8'h00;
        run(1'b1, 4'd0, 4'd0, e);
        n_cmp++; if (e !== 16) begin n_bad++; $display("FAIL inv_latency: got %0d expected 16", e); end
        n_cmp++; if (err_cnt !== 4'd8) begin n_bad++; $display("FAIL inv_err_cnt: got %0d expected 8", err_cnt); end
        n_cmp++; if (first_fail !== 3'd0) begin n_bad++; $display("FAIL inv_first_fail: got %0d expected 0", first_fail); end
        n_cmp++; if (fail_valid !== 1'b1) begin n_bad++; $display("FAIL inv_fail_valid: got %b expected 1", fail_valid); end
        n_cmp++; if (post_pass !== 1'b0) begin n_bad++; $display("FAIL inv_pass: got %b expected 0", post_pass); end
    endtask

    task automatic test_single_fault();
        int e;
        fault_mask = 8'b0010_0000;
        run(1'b0, 4'd3, 4'd3, e);
        n_cmp++; if (e !== 40) begin n_bad++; $display("FAIL fault_latency: got %0d expected 40", e); end
        n_cmp++; if (err_cnt !== 4'd1) begin n_bad++; $display("FAIL fault_err_cnt: got %0d expected 1", err_cnt); end
        n_cmp++; if (first_fail !== 3'd5) begin n_bad++; $display("FAIL fault_first_fail: got %0d expected 5", first_fail); end
        n_cmp++; if (fail_valid !== 1'b1) begin n_bad++; $display("FAIL fault_fail_valid: got %b expected 1", fail_valid); end
        n_cmp++; if (pass_seen !== 1'b0) begin n_bad++; $display("FAIL fault_pass_seen: got %b expected 0", pass_seen); end
        fault_mask = 8'h00;
    endtask

    task automatic test_settle_change();
        int e;
        fault_mask = 8'h00;
        run(1'b0, 4'd2, 4'd9, e);
        n_cmp++; if (e !== 32) begin n_bad++; $display("FAIL settle_latency: got %0d expected 32", e); end
        n_cmp++; if (err_cnt !== 4'd0) begin n_bad++; $display("FAIL settle_err_cnt: got %0d expected 0", err_cnt); end
        n_cmp++; if (post_pass !== 1'b1) begin n_bad++; $display("FAIL settle_pass: got %b expected 1", post_pass); end
    endtask

    task automatic test_back_to_back();
        int e1, e2;
        fault_mask = 8'h00;
        @(negedge clk);
        parity_sel = 1'b1;
        settle     = 4'd0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        parity_sel = 1'b0;
        e1 = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done) begin e1 = n; break; end
        end
        n_cmp++; if (e1 !== 16) begin n_bad++; $display("FAIL b2b_first_latency: got %0d expected 16", e1); end
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap: busy got %b expected 0", busy); end
        n_cmp++; if (err_cnt !== 4'd8) begin n_bad++; $display("FAIL b2b_first_err: got %0d expected 8", err_cnt); end
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_reaccept: busy got %b expected 1", busy); end
        n_cmp++; if (err_cnt !== 4'd0) begin n_bad++; $display("FAIL b2b_err_cleared: got %0d expected 0", err_cnt); end
        n_cmp++; if (fail_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_fv_cleared: got %b expected 0", fail_valid); end
        e2 = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done) begin e2 = n; break; end
        end
        n_cmp++; if (e2 !== 16) begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected 16", e2); end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL b2b_second_pass: got %b expected 1", pass); end
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_stop: busy got %b expected 0", busy); end
    endtask

    task automatic test_rst_mid_run();
        int   e;
        logic seen;
        fault_mask = 8'h00;
        @(negedge clk);
        parity_sel = 1'b1;
        settle     = 4'd3;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        n_cmp++; if (dvec !== 3'd3) begin n_bad++; $display("FAIL rst_pre_vec: got %0d expected 3", dvec); end
        n_cmp++; if (err_cnt !== 4'd3) begin n_bad++; $display("FAIL rst_pre_err: got %0d expected 3", err_cnt); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
        n_cmp++; if (dvec !== 3'd0) begin n_bad++; $display("FAIL rst_async_vec: got %0d expected 0", dvec); end
        n_cmp++; if (err_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_async_err: got %0d expected 0", err_cnt); end
        n_cmp++; if (fail_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async_fv: got %b expected 0", fail_valid); end
        n_cmp++; if (first_fail !== 3'd0) begin n_bad++; $display("FAIL rst_async_ff: got %0d expected 0", first_fail); end
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_no_done_no_resume: got %b expected 0", seen); end
        run(1'b0, 4'd0, 4'd0, e);
        n_cmp++; if (e !== 16) begin n_bad++; $display("FAIL rst_rerun_latency: got %0d expected 16", e); end
        n_cmp++; if (err_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_rerun_err: got %0d expected 0", err_cnt); end
        n_cmp++; if (post_pass !== 1'b1) begin n_bad++; $display("FAIL rst_rerun_pass: got %b expected 1", post_pass); end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        parity_sel = 1'b0;
        settle     = 4'd0;
        fault_mask = 8'h00;
        test_reset();
        test_good_run();
        test_inverted_sel();
        test_single_fault();
        test_settle_change();
        test_back_to_back();
        test_rst_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
